pipe_cla_alu: RTL and testbench

PIPE_CLA_ALU -- requirements
Module: pipe_cla_alu

---
 rtl/pipe_cla_alu_if.sv | 14 +
 rtl/pipe_cla_alu.sv | 60 ++++++
 tb/tb_pipe_cla_alu.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_cla_alu_if.sv
// pipe_cla_alu_if: operand/result handshake bundle for pipe_cla_alu
interface pipe_cla_alu_if #(parameter int N = 16);
  logic in_valid;
  logic in_ready;
  logic [1:0] op;
  logic signed [N-1:0] a;
  logic signed [N-1:0] b;
  logic out_valid;
  logic out_ready;
  logic signed [N-1:0] result;
  logic [4:0] flags;
  modport master (output in_valid, op, a, b, out_ready, input in_ready, out_valid, result, flags);
  modport slave (input in_valid, op, a, b, out_ready, output in_ready, out_valid, result, flags);
endinterface

// File: rtl/pipe_cla_alu.sv
// pipe_cla_alu: pipelined carry-look-ahead ADD/SUB/ADC/SBC with global stall; parity flag only with PIPE_CLA_ALU_PARITY_EN
module pipe_cla_alu #(
  parameter int N = 16,
  parameter int STAGES = 2
) (
  input logic clk,
  input logic rst,
  pipe_cla_alu_if.slave bus
);
  localparam int W = N + 5;
  logic [N-1:0] x, g, p, gk, pk, c, s;
  logic cin, cout, cflag, stall, issue, par;
  logic [W-1:0] nxt;
  logic [STAGES-1:0] vld;
  logic [W-1:0] dat [STAGES];
  assign stall = vld[STAGES-1] && !bus.out_ready;
  assign issue = bus.in_valid && !stall;
  assign bus.in_ready = !stall;
  assign x = bus.op[0] ? ~bus.b : bus.b;
  assign cin = bus.op[1] ? cflag : bus.op[0];
  // Kogge-Stone prefix: gk[i] ends as the carry out of bit i
  always_comb begin
    g = bus.a & x;
    p = bus.a ^ x;
    gk = g;
    pk = p;
    gk[0] = g[0] | (p[0] & cin);
    for (int d = 1; d < N; d = d * 2)
      for (int i = N - 1; i >= d; i--) begin
        gk[i] = gk[i] | (pk[i] & gk[i-d]);
        pk[i] = pk[i] & pk[i-d];
      end
  end
  assign c = {gk[N-2:0], cin};
  assign s = p ^ c;
  assign cout = gk[N-1];
`ifdef PIPE_CLA_ALU_PARITY_EN
  assign par = ~^s;
`else
  assign par = 1'b0;
`endif
  assign nxt = {s, c[N-1] ^ cout, cout, s[N-1], s == '0, par};
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      cflag <= 1'b0;
      for (int k = 0; k < STAGES; k++) dat[k] <= '0;
    end else if (!stall) begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        vld[k] <= vld[k-1];
        dat[k] <= dat[k-1];
      end
      vld[0] <= issue;
      dat[0] <= issue ? nxt : '0;
      if (issue) cflag <= cout;
    end
  end
  assign bus.out_valid = vld[STAGES-1];
  assign {bus.result, bus.flags} = bus.out_valid ? dat[STAGES-1] : '0;
endmodule

// File: tb/tb_pipe_cla_alu.sv
// tb_pipe_cla_alu: directed checks of pipe_cla_alu (N=16, STAGES=2); P expectations masked when parity is not built
module tb_pipe_cla_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
`ifdef PIPE_CLA_ALU_PARITY_EN
  localparam logic [4:0] PM = 5'b11111;
`else
  localparam logic [4:0] PM = 5'b11110;
`endif
  pipe_cla_alu_if #(.N(16)) ai();
  pipe_cla_alu #(.N(16), .STAGES(2)) dut (.clk(clk), .rst(rst), .bus(ai));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    ai.in_valid = v;
    ai.op = o;
    ai.a = x;
    ai.b = y;
  endtask

  task automatic test_reset;
    drive(1'b0, 2'd0, 16'h0, 16'h0);
    ai.out_ready = 1'b1;
    rst = 1'b1;
    tick;
    tick;
    n_cmp++;
    if (ai.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", ai.out_valid); end
    n_cmp++;
    if ({ai.result, ai.flags} !== 21'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", {ai.result, ai.flags}); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ai.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", ai.in_ready); end
  endtask

  task automatic test_add_overflow;
    drive(1'b1, 2'd0, 16'h7FFF, 16'h0001);
    #1;
    n_cmp++;
    if (ai.in_ready !== 1'b1) begin n_err++; $display("FAIL ovf_in_ready: got %b expected 1", ai.in_ready); end
    tick;
    drive(1'b0, 2'd0, 16'h0, 16'h0);
    n_cmp++;
    if (ai.out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_early_valid: got %b expected 0", ai.out_valid); end
    tick;
    n_cmp++;
    if ({ai.out_valid, ai.result, ai.flags} !== {1'b1, 16'h8000, 5'b10100 & PM})
      begin n_err++; $display("FAIL ovf_result: got %h expected %h", {ai.out_valid, ai.result, ai.flags}, {1'b1, 16'h8000, 5'b10100 & PM}); end
    tick;
    n_cmp++;
    if ({ai.out_valid, ai.result, ai.flags} !== 22'h0) begin n_err++; $display("FAIL ovf_drain: got %h expected 0", {ai.out_valid, ai.result, ai.flags}); end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 2'd0, 16'hFFFF, 16'h0001);
    tick;
    drive(1'b1, 2'd2, 16'h0000, 16'h0000);
    tick;
    drive(1'b0, 2'd0, 16'h0, 16'h0);
    n_cmp++;
    if ({ai.out_valid, ai.result, ai.flags} !== {1'b1, 16'h0000, 5'b01011 & PM})
      begin n_err++; $display("FAIL b2b_add: got %h expected %h", {ai.out_valid, ai.result, ai.flags}, {1'b1, 16'h0000, 5'b01011 & PM}); end
    tick;
    n_cmp++;
    if ({ai.out_valid, ai.result, ai.flags} !== {1'b1, 16'h0001, 5'b00000})
      begin n_err++; $display("FAIL b2b_adc: got %h expected %h", {ai.out_valid, ai.result, ai.flags}, {1'b1, 16'h0001, 5'b00000}); end
    tick;
  endtask

  task automatic test_sub;
    drive(1'b1, 2'd1, 16'h0005, 16'h0005);
    tick;
    drive(1'b1, 2'd1, 16'h0000, 16'h0001);
    tick;
    drive(1'b0, 2'd0, 16'h0, 16'h0);
    n_cmp++;
    if ({ai.out_valid, ai.result, ai.flags} !== {1'b1, 16'h0000, 5'b01011 & PM})
      begin n_err++; $display("FAIL sub_equal: got %h expected %h", {ai.out_valid, ai.result, ai.flags}, {1'b1, 16'h0000, 5'b01011 & PM}); end
    tick;
    n_cmp++;
    if ({ai.out_valid, ai.result, ai.flags} !== {1'b1, 16'hFFFF, 5'b00101 & PM})
      begin n_err++; $display("FAIL sub_borrow: got %h expected %h", {ai.out_valid, ai.result, ai.flags}, {1'b1, 16'hFFFF, 5'b00101 & PM}); end
    tick;
  endtask

  task automatic test_stall;
    logic [1:0] ops [4] = '{2'd0, 2'd0, 2'd1, 2'd0};
    logic [15:0] as [4] = '{16'h0001, 16'h0002, 16'h000A, 16'h0100};
    logic [15:0] bs [4] = '{16'h0001, 16'h0003, 16'h0003, 16'h00FF};
    logic [15:0] er [4] = '{16'h0002, 16'h0005, 16'h0007, 16'h01FF};
    logic [4:0] ef [4] = '{5'b00000, 5'b00001, 5'b01000, 5'b00000};
    logic [20:0] hold = '0;
    int iss = 0;
    int got = 0;
    int sc = -1;
    logic acc;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      int j = iss < 4 ? iss : 3;
      if (ai.out_valid && sc < 0) sc = 0;
      ai.out_ready = !(sc >= 0 && sc < 5);
      drive(iss < 4, ops[j], as[j], bs[j]);
      #1;
      if (!ai.out_ready) begin
        n_cmp++;
        if (ai.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %b expected 0 (stall cycle %0d)", ai.in_ready, sc); end
        if (sc == 0) hold = {ai.result, ai.flags};
        else begin
          n_cmp++;
          if ({ai.result, ai.flags} !== hold) begin n_err++; $display("FAIL stall_hold: got %h expected %h", {ai.result, ai.flags}, hold); end
        end
        sc++;
      end
      acc = ai.in_valid && ai.in_ready;
      if (ai.out_valid && ai.out_ready) begin
        n_cmp++;
        if ({ai.result, ai.flags} !== {er[got], ef[got] & PM})
          begin n_err++; $display("FAIL stall_order[%0d]: got %h expected %h", got, {ai.result, ai.flags}, {er[got], ef[got] & PM}); end
        got++;
      end
      tick;
      if (acc) iss++;
    end
    n_cmp++;
    if (got != 4) begin n_err++; $display("FAIL stall_timeout: got %0d results expected 4", got); end
    drive(1'b0, 2'd0, 16'h0, 16'h0);
    ai.out_ready = 1'b1;
    tick;
    tick;
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 2'd0, 16'hFFFF, 16'h0001);
    tick;
    drive(1'b1, 2'd0, 16'hFFFF, 16'h0001);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    drive(1'b0, 2'd0, 16'h0, 16'h0);
    #1;
    n_cmp++;
    if (ai.in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready: got %b expected 1", ai.in_ready); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (ai.out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_ghost[%0d]: got %b expected 0", i, ai.out_valid); end
      tick;
    end
    drive(1'b1, 2'd2, 16'h0001, 16'h0001);
    tick;
    drive(1'b0, 2'd0, 16'h0, 16'h0);
    tick;
    n_cmp++;
    if ({ai.out_valid, ai.result, ai.flags} !== {1'b1, 16'h0002, 5'b00000})
      begin n_err++; $display("FAIL rstmid_cflag: got %h expected %h", {ai.out_valid, ai.result, ai.flags}, {1'b1, 16'h0002, 5'b00000}); end
    tick;
  endtask

  task automatic test_zero;
    drive(1'b1, 2'd0, 16'h0000, 16'h0000);
    tick;
    drive(1'b0, 2'd0, 16'h0, 16'h0);
    tick;
    n_cmp++;
    if ({ai.out_valid, ai.result, ai.flags} !== {1'b1, 16'h0000, 5'b00011 & PM})
      begin n_err++; $display("FAIL zero_add: got %h expected %h", {ai.out_valid, ai.result, ai.flags}, {1'b1, 16'h0000, 5'b00011 & PM}); end
    tick;
  endtask

  initial begin
    test_reset;
    test_add_overflow;
    test_back_to_back;
    test_sub;
    test_stall;
    test_reset_mid;
    test_zero;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
